// File: rtl/qspi_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package  : qspi_bus_pkg
// Purpose  : Shared FSM encoding, transfer-size and chip-select constants for
//            the QSPI bus arbiter and its address decoder.
// Revision : 1.0 - initial release
// ============================================================================
package qspi_bus_pkg;

    typedef logic [2:0] state_t;

    localparam state_t c_st_idle  = 3'd0;
    localparam state_t c_st_issue = 3'd1;
    localparam state_t c_st_wait  = 3'd2;
    localparam state_t c_st_resp  = 3'd3;
    localparam state_t c_st_gap   = 3'd4;

    localparam logic [1:0] c_size_byte = 2'd0;
    localparam logic [1:0] c_size_half = 2'd1;
    localparam logic [1:0] c_size_word = 2'd2;
    localparam logic [1:0] c_size_bad  = 2'd3;

    localparam logic c_sel_flash = 1'b0;
    localparam logic c_sel_psram = 1'b1;

    // Grant identifiers double as the requester select for the winner mux.
    localparam logic c_grant_i = 1'b0;
    localparam logic c_grant_d = 1'b1;

endpackage : qspi_bus_pkg
`default_nettype wire

// File: rtl/qspi_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : qspi_addr_decode
// Purpose  : Combinational window select / illegal-access decode for the
//            arbitration winner's address, direction and size.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_addr_decode
    import qspi_bus_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] PSRAM_BASE_ADDR = 32'h0100_0000
) (
    input  logic [31:0] i_addr,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    output logic        o_sel,
    output logic [23:0] o_offset,
    output logic        o_err
);

    logic w_hit_flash;
    logic w_hit_psram;

    assign w_hit_flash = (i_addr[31:24] == FLASH_BASE_ADDR[31:24]);
    assign w_hit_psram = (i_addr[31:24] == PSRAM_BASE_ADDR[31:24]);

    // Flash wins if both windows were ever configured onto the same page.
    assign o_sel    = w_hit_flash ? c_sel_flash : c_sel_psram;
    assign o_offset = i_addr[23:0];
    assign o_err    = (!w_hit_flash && !w_hit_psram)
                    || (w_hit_flash && i_we)
                    || (i_size == c_size_bad);

endmodule : qspi_addr_decode
`default_nettype wire

// File: rtl/qspi_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qspi_bus_arbiter
// Purpose  : Arbitrates the fetch and data ports onto one QSPI engine with
//            alternating priority, window decode and a chip-select idle gap.
// Revision : 1.0 - initial release
// ============================================================================
module qspi_bus_arbiter
    import qspi_bus_pkg::*;
#(
    parameter logic [31:0] FLASH_BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] PSRAM_BASE_ADDR = 32'h0100_0000,
    parameter int          CS_GAP          = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        eng_start,
    output logic        eng_sel,
    output logic [23:0] eng_addr,
    output logic        eng_we,
    output logic [1:0]  eng_size,
    output logic [31:0] eng_wdata,
    input  logic        eng_done,
    input  logic [31:0] eng_rdata,
    output logic        busy
);

    localparam int                 c_gap_w    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(CS_GAP - 1);
    localparam logic               c_has_gap  = (CS_GAP > 0);

    state_t             r_state;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic               r_last_grant;
    logic               r_grant;
    logic               r_used_eng;

    logic               r_eng_start;
    logic               r_eng_sel;
    logic [23:0]        r_eng_addr;
    logic               r_eng_we;
    logic [1:0]         r_eng_size;
    logic [31:0]        r_eng_wdata;

    logic               r_i_ack;
    logic               r_i_err;
    logic [31:0]        r_i_rdata;
    logic               r_d_ack;
    logic               r_d_err;
    logic [31:0]        r_d_rdata;

    logic               w_any_req;
    logic               w_pick_d;
    logic [31:0]        w_win_addr;
    logic               w_win_we;
    logic [1:0]         w_win_size;
    logic [31:0]        w_win_wdata;
    logic               w_dec_sel;
    logic [23:0]        w_dec_offset;
    logic               w_dec_err;

    // Data wins only when fetch is idle or fetch held the previous grant.
    assign w_any_req   = i_req | d_req;
    assign w_pick_d    = d_req & (~i_req | (r_last_grant == c_grant_i));
    assign w_win_addr  = w_pick_d ? d_addr : i_addr;
    assign w_win_we    = w_pick_d & d_we;
    assign w_win_size  = w_pick_d ? d_size : c_size_word;
    assign w_win_wdata = w_pick_d ? d_wdata : 32'h0000_0000;

    qspi_addr_decode #(
        .FLASH_BASE_ADDR (FLASH_BASE_ADDR),
        .PSRAM_BASE_ADDR (PSRAM_BASE_ADDR)
    ) u_addr_decode (
        .i_addr   (w_win_addr),
        .i_we     (w_win_we),
        .i_size   (w_win_size),
        .o_sel    (w_dec_sel),
        .o_offset (w_dec_offset),
        .o_err    (w_dec_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_gap_cnt    <= '0;
            r_last_grant <= c_grant_d;
            r_grant      <= c_grant_d;
            r_used_eng   <= 1'b0;
            r_eng_start  <= 1'b0;
            r_eng_sel    <= 1'b0;
            r_eng_addr   <= 24'h00_0000;
            r_eng_we     <= 1'b0;
            r_eng_size   <= 2'd0;
            r_eng_wdata  <= 32'h0000_0000;
            r_i_ack      <= 1'b0;
            r_i_err      <= 1'b0;
            r_i_rdata    <= 32'h0000_0000;
            r_d_ack      <= 1'b0;
            r_d_err      <= 1'b0;
            r_d_rdata    <= 32'h0000_0000;
        end else begin
            r_eng_start <= 1'b0;
            r_i_ack     <= 1'b0;
            r_i_err     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_d_err     <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_last_grant <= w_pick_d;
                        r_grant      <= w_pick_d;
                        if (w_dec_err) begin
                            // Illegal access answers straight away without touching the engine.
                            r_used_eng <= 1'b0;
                            r_state    <= c_st_resp;
                            if (w_pick_d) begin
                                r_d_ack <= 1'b1;
                                r_d_err <= 1'b1;
                            end else begin
                                r_i_ack <= 1'b1;
                                r_i_err <= 1'b1;
                            end
                        end else begin
                            r_used_eng  <= 1'b1;
                            r_eng_start <= 1'b1;
                            r_eng_sel   <= w_dec_sel;
                            r_eng_addr  <= w_dec_offset;
                            r_eng_we    <= w_win_we;
                            r_eng_size  <= w_win_size;
                            r_eng_wdata <= w_win_wdata;
                            r_state     <= c_st_issue;
                        end
                    end
                end

                c_st_issue: begin
                    r_state <= c_st_wait;
                end

                c_st_wait: begin
                    if (eng_done) begin
                        if (r_grant == c_grant_d) begin
                            r_d_ack   <= 1'b1;
                            r_d_rdata <= eng_rdata;
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= eng_rdata;
                        end
                        r_state <= c_st_resp;
                    end
                end

                c_st_resp: begin
                    if (c_has_gap && r_used_eng) begin
                        r_gap_cnt <= '0;
                        r_state   <= c_st_gap;
                    end else begin
                        r_state <= c_st_idle;
                    end
                end

                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_gap_cnt <= '0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign eng_start = r_eng_start;
    assign eng_sel   = r_eng_sel;
    assign eng_addr  = r_eng_addr;
    assign eng_we    = r_eng_we;
    assign eng_size  = r_eng_size;
    assign eng_wdata = r_eng_wdata;
    assign i_ack     = r_i_ack;
    assign i_err     = r_i_err;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;
    assign busy      = (r_state != c_st_idle);

endmodule : qspi_bus_arbiter
`default_nettype wire

// File: tb/tb_qspi_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_qspi_bus_arbiter
// Purpose  : Scoreboard bench for qspi_bus_arbiter with a behavioural engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_qspi_bus_arbiter;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          chk_rdata;
        bit          err;
    } rsp_t;

    typedef struct {
        logic        sel;
        logic [23:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
    } eng_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = '0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        eng_start;
    logic        eng_sel;
    logic [23:0] eng_addr;
    logic        eng_we;
    logic [1:0]  eng_size;
    logic [31:0] eng_wdata;
    logic        eng_done;
    logic [31:0] eng_rdata = '0;
    logic        busy;
    logic        model_done = 1'b0;
    logic        stray_done = 1'b0;

    rsp_t        sb_q[$];
    eng_t        eng_q[$];
    logic [31:0] data_q[$];

    int errors        = 0;
    int checks        = 0;
    int cyc           = 0;
    int eng_delay     = 10;
    int last_done_cyc = -1;
    int last_start_cyc = -1;

    assign eng_done = model_done | stray_done;

    qspi_bus_arbiter #(
        .FLASH_BASE_ADDR (32'h0000_0000),
        .PSRAM_BASE_ADDR (32'h0100_0000),
        .CS_GAP          (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_rdata   (i_rdata),
        .i_err     (i_err),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .eng_start (eng_start),
        .eng_sel   (eng_sel),
        .eng_addr  (eng_addr),
        .eng_we    (eng_we),
        .eng_size  (eng_size),
        .eng_wdata (eng_wdata),
        .eng_done  (eng_done),
        .eng_rdata (eng_rdata),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine model: eng_done arrives eng_delay cycles after the eng_start cycle.
    initial begin
        bit pend;
        int cnt;
        pend = 0;
        cnt  = 0;
        forever begin
            @(posedge clk);
            #1;
            model_done = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        model_done = 1'b1;
                        eng_rdata  = (data_q.size() != 0) ? data_q.pop_front() : 32'h0;
                        pend       = 0;
                    end
                end
                if (eng_start) begin
                    pend = 1;
                    cnt  = eng_delay;
                end
            end
        end
    end

    // Monitor: engine launches against eng_q, acks against sb_q.
    initial begin
        eng_t e;
        rsp_t r;
        logic obs_err;
        logic [31:0] obs_rd;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (eng_done) last_done_cyc = cyc;
                if (eng_start) begin
                    checks++;
                    if (eng_q.size() == 0) begin
                        errors++;
                        $display("FAIL eng_start_unexpected: got eng_start=1 at cycle %0d, required 0", cyc);
                    end else begin
                        e = eng_q.pop_front();
                        if ({eng_sel, eng_addr, eng_we, eng_size} !== {e.sel, e.addr, e.we, e.size}) begin
                            errors++;
                            $display("FAIL eng_fields: got sel=%0b addr=%h we=%0b size=%0d, required sel=%0b addr=%h we=%0b size=%0d",
                                     eng_sel, eng_addr, eng_we, eng_size, e.sel, e.addr, e.we, e.size);
                        end
                        if (e.we) begin
                            checks++;
                            if (eng_wdata !== e.wdata) begin
                                errors++;
                                $display("FAIL eng_wdata: got %h, required %h", eng_wdata, e.wdata);
                            end
                        end
                    end
                    if (last_done_cyc >= 0) begin
                        checks++;
                        if (cyc - last_done_cyc <= 3) begin
                            errors++;
                            $display("FAIL cs_gap: eng_start %0d cycles after eng_done, required more than 3", cyc - last_done_cyc);
                        end
                    end
                    last_start_cyc = cyc;
                end
                if (i_ack || d_ack) begin
                    checks++;
                    if (i_ack && d_ack) begin
                        errors++;
                        $display("FAIL dual_ack: got i_ack=1 d_ack=1, required one");
                    end else if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL ack_unexpected: got i_ack=%0b d_ack=%0b at cycle %0d, required none", i_ack, d_ack, cyc);
                    end else begin
                        r = sb_q.pop_front();
                        if (d_ack !== r.is_d) begin
                            errors++;
                            $display("FAIL ack_port: got d_ack=%0b, required d_ack=%0b", d_ack, r.is_d);
                        end
                        checks++;
                        obs_err = r.is_d ? d_err : i_err;
                        if (obs_err !== r.err) begin
                            errors++;
                            $display("FAIL ack_err: got err=%0b, required %0b", obs_err, r.err);
                        end
                        if (r.chk_rdata) begin
                            checks++;
                            obs_rd = r.is_d ? d_rdata : i_rdata;
                            if (obs_rd !== r.rdata) begin
                                errors++;
                                $display("FAIL ack_rdata: got %h, required %h", obs_rd, r.rdata);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] data);
        sb_q.push_back('{is_d: 1'b0, rdata: data, chk_rdata: 1'b1, err: 1'b0});
        eng_q.push_back('{sel: addr[24], addr: addr[23:0], we: 1'b0, size: 2'd2, wdata: 32'h0});
        data_q.push_back(data);
    endtask

    task automatic wait_ack(input bit want_d, input int bound, output int ack_cyc);
        ack_cyc = -1;
        for (int k = 0; k < bound && ack_cyc < 0; k++) begin
            @(negedge clk);
            if (want_d ? d_ack : i_ack) ack_cyc = cyc;
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({eng_start, eng_sel, eng_addr, eng_we, eng_size, eng_wdata, i_ack, i_err, i_rdata,
             d_ack, d_err, d_rdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got start=%0b addr=%h i_ack=%0b d_ack=%0b busy=%0b, required all 0",
                     eng_start, eng_addr, i_ack, d_ack, busy);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %0b, required 0", busy);
        end
    endtask

    task automatic test_dual_arbitration();
        int n_i;
        bit ok;
        eng_delay = 4;
        push_fetch(32'h0000_0200, 32'hA5A5_0001);
        sb_q.push_back('{is_d: 1'b1, rdata: 32'h0, chk_rdata: 1'b0, err: 1'b0});
        eng_q.push_back('{sel: 1'b1, addr: 24'h00_0010, we: 1'b1, size: 2'd2, wdata: 32'h1234_5678});
        data_q.push_back(32'h0BAD_F00D);
        push_fetch(32'h0000_0204, 32'hA5A5_0002);
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_addr = 32'h0100_0010; d_we = 1'b1; d_size = 2'd2; d_wdata = 32'h1234_5678;
        n_i = 0;
        for (int k = 0; k < 300 && (i_req || d_req); k++) begin
            @(negedge clk);
            if (i_ack) begin
                n_i++;
                if (n_i == 1) i_addr = 32'h0000_0204;
                else i_req = 1'b0;
            end
            if (d_ack) d_req = 1'b0;
        end
        d_we = 1'b0;
        checks++;
        if (i_req || d_req || sb_q.size() != 0) begin
            errors++;
            $display("FAIL dual_complete: got pending i=%0b d=%0b sb=%0d, required all done", i_req, d_req, sb_q.size());
        end
        wait_idle(20, ok);
    endtask

    task automatic test_fetch_basic();
        int ack_c;
        int start_c;
        bit ok;
        eng_delay = 10;
        push_fetch(32'h0000_0100, 32'hDEAD_BEEF);
        i_req = 1'b1; i_addr = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (eng_start !== 1'b1) begin
            errors++;
            $display("FAIL fetch_latency: got eng_start=%0b one cycle after request, required 1", eng_start);
        end
        start_c = cyc;
        wait_ack(1'b0, 40, ack_c);
        i_req = 1'b0;
        checks++;
        if (ack_c - start_c != 11) begin
            errors++;
            $display("FAIL fetch_ack_timing: got ack %0d cycles after eng_start, required 11", ack_c - start_c);
        end
        wait_idle(20, ok);
    endtask

    task automatic test_back_to_back();
        int ack_c;
        int start2;
        int low_cnt;
        bit ok;
        eng_delay = 3;
        push_fetch(32'h0000_0300, 32'h1111_0300);
        push_fetch(32'h0000_0304, 32'h1111_0304);
        i_req = 1'b1; i_addr = 32'h0000_0300;
        wait_ack(1'b0, 40, ack_c);
        i_addr = 32'h0000_0304;
        start2  = -1;
        low_cnt = 0;
        for (int k = 0; k < 20 && start2 < 0; k++) begin
            @(negedge clk);
            if (eng_start) start2 = cyc;
            else if (!busy) low_cnt++;
        end
        checks++;
        if (start2 - ack_c != 4 || low_cnt != 1) begin
            errors++;
            $display("FAIL gap_cycles: got start %0d cycles after ack with %0d idle, required 4 and 1", start2 - ack_c, low_cnt);
        end
        wait_ack(1'b0, 40, ack_c);
        i_req = 1'b0;
        checks++;
        if (ack_c < 0) begin
            errors++;
            $display("FAIL b2b_timeout: got no second i_ack, required one");
        end
        wait_idle(20, ok);
    endtask

    task automatic test_errors();
        bit          t_d  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] t_a  [4] = '{32'h0000_0040, 32'h0500_0000, 32'h0100_0000, 32'h0200_0000};
        logic        t_we [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  t_sz [4] = '{2'd2, 2'd2, 2'd3, 2'd2};
        for (int n = 0; n < 4; n++) begin
            sb_q.push_back('{is_d: t_d[n], rdata: 32'h0, chk_rdata: 1'b0, err: 1'b1});
            if (t_d[n]) begin
                d_req = 1'b1; d_addr = t_a[n]; d_we = t_we[n]; d_size = t_sz[n];
            end else begin
                i_req = 1'b1; i_addr = t_a[n];
            end
            @(negedge clk);
            checks++;
            if ((t_d[n] ? d_ack : i_ack) !== 1'b1) begin
                errors++;
                $display("FAIL err_ack_latency[%0d]: got ack=%0b, required 1", n, t_d[n] ? d_ack : i_ack);
            end
            d_req = 1'b0; i_req = 1'b0; d_we = 1'b0;
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || i_ack !== 1'b0 || d_ack !== 1'b0) begin
                errors++;
                $display("FAIL err_bus_free[%0d]: got busy=%0b acks=%0b%0b, required 0", n, busy, i_ack, d_ack);
            end
        end
    endtask

    task automatic test_stray_done();
        @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: got busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int ack_c;
        bit ok;
        eng_delay = 20;
        eng_q.push_back('{sel: 1'b0, addr: 24'h00_0400, we: 1'b0, size: 2'd2, wdata: 32'h0});
        i_req = 1'b1; i_addr = 32'h0000_0400;
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({eng_start, eng_sel, eng_addr, eng_we, eng_size, eng_wdata, i_ack, i_err, i_rdata,
             d_ack, d_err, d_rdata, busy} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%0b addr=%h i_rdata=%h, required all 0", busy, eng_addr, i_rdata);
        end
        i_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        eng_delay = 5;
        push_fetch(32'h0000_0500, 32'hCAFE_F00D);
        i_req = 1'b1; i_addr = 32'h0000_0500;
        wait_ack(1'b0, 40, ack_c);
        i_req = 1'b0;
        checks++;
        if (ack_c < 0) begin
            errors++;
            $display("FAIL reset_recover: got no i_ack after reset, required one");
        end
        wait_idle(20, ok);
    endtask

    initial begin
        test_reset();
        test_dual_arbitration();
        test_fetch_basic();
        test_back_to_back();
        test_errors();
        test_stray_done();
        test_reset_mid();
        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || eng_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d acks and %0d launches outstanding, required 0", sb_q.size(), eng_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_qspi_bus_arbiter
`default_nettype wire

// File: doc/qspi_bus_arbiter.md
QSPI_BUS_ARBITER -- requirements
Module: qspi_bus_arbiter

Interface
REQ-001 Parameter FLASH_BASE_ADDR, default 32'h00000000, base of 16 MiB flash window.
REQ-002 Parameter PSRAM_BASE_ADDR, default 32'h01000000, base of 16 MiB PSRAM window.
REQ-003 Parameter CS_GAP, default 2, idle cycles enforced between consecutive engine transactions (0 allowed).
REQ-004 The block SHALL use one clock, clk; reset, rst, is asynchronous and active-high.
REQ-005 Ports (name  direction  width  meaning):
 clk  in  1  system clock
 rst  in  1  async active-high reset
 i_req  in  1  instruction-fetch request, held until i_ack
 i_addr  in  32  fetch byte address
 i_ack  out  1  one-cycle completion pulse
 i_rdata  out  32  fetch data, valid with i_ack
 i_err  out  1  decode error, valid with i_ack
 d_req  in  1  data request, held until d_ack
 d_addr  in  32  data byte address
 d_we  in  1  1 = write
 d_size  in  2  0 byte, 1 half, 2 word
 d_wdata  in  32  write data
 d_ack  out  1  one-cycle completion pulse
 d_rdata  out  32  read data, valid with d_ack
 d_err  out  1  error, valid with d_ack
 eng_start  out  1  one-cycle transaction launch to QSPI engine
 eng_sel  out  1  0 = flash CS, 1 = PSRAM CS
 eng_addr  out  24  window offset
 eng_we  out  1  write
 eng_size  out  2  transfer size
 eng_wdata  out  32  write data
 eng_done  in  1  one-cycle engine completion pulse
 eng_rdata  in  32  engine read data, valid with eng_done
 busy  out  1  high whenever state != IDLE

Function
REQ-006 FSM states IDLE, ISSUE, WAIT, RESP, GAP; reset state IDLE.
REQ-007 IDLE: if any req pending, select winner, decode, register eng_* fields, go ISSUE (legal) or RESP with error (illegal).
REQ-008 Both req high in IDLE: grant the requester not granted last; last_grant resets to D so fetch wins first.
REQ-009 Decode: addr[31:24]==FLASH_BASE_ADDR[31:24] -> eng_sel=0; ==PSRAM_BASE_ADDR[31:24] -> eng_sel=1; eng_addr=addr[23:0].
REQ-010 Error cases: address in neither window, or d_we=1 to flash, or d_size=3 -> no eng_start, err=1 with ack.
REQ-011 Fetch transactions SHALL force eng_we=0, eng_size=2.
REQ-012 ISSUE: eng_start=1 for exactly one cycle, next state WAIT; latency i_req/d_req sampled at edge N -> eng_start high in cycle N+1.
REQ-013 WAIT: hold eng_* stable; on eng_done capture eng_rdata, go RESP; other cycles stay.
REQ-014 RESP: pulse ack (and err if applicable) to granted requester only, rdata registered value; next GAP if CS_GAP>0 and an engine transaction occurred, else IDLE.
REQ-015 GAP: count CS_GAP cycles, then IDLE; requests during GAP wait.
REQ-016 eng_done outside WAIT SHALL be ignored.
REQ-017 last_grant SHALL update on every grant, including error grants.
REQ-018 Requester dropping req mid-transaction: transaction completes, ack still pulsed (protocol violation, not detected).
REQ-019 rdata outputs hold last value between acks; i_rdata/d_rdata independent registers.

Reset
REQ-020 On rst: state IDLE, gap counter 0, last_grant=D, all outputs 0 (eng_*, acks, errs, rdata, busy) immediately, independent of clk.
REQ-021 Reset mid-transaction SHALL abandon it without ack; engine shares rst.

Structure
REQ-022 Shared package qspi_bus_pkg holds FSM state enum, size encoding constants, window-select constants.
REQ-023 One sub-module, qspi_addr_decode (combinational window/error decode), is instantiated once on the winner's fields.

Verification
REQ-024 Fetch 0x00000100, engine done after 10 cycles with 0xDEADBEEF -> eng_sel=0, eng_addr=0x000100, i_ack with i_rdata=0xDEADBEEF, i_err=0.
REQ-025 i_req and d_req (write 0x01000010, word 0x12345678) same cycle -> fetch granted first, then data with eng_sel=1, eng_we=1; next dual request -> data first.
REQ-026 CS_GAP=2, back-to-back fetches -> exactly 2 GAP cycles between RESP and next ISSUE; eng_start never within 3 cycles after prior eng_done.
REQ-027 d_we=1 to 0x00000040, and read to 0x05000000 -> d_ack with d_err=1, no eng_start, bus free next cycle.
REQ-028 rst asserted in WAIT -> outputs 0 same cycle, no ack; after release fetch completes normally.
